hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard and control unit for the 5-stage pipelined CPU, sitting between the IF/ID and ID/EX pipeline registers and the PC mux. It detects load-use hazards and holds the front end for a configurable number of cycles. It redirects fetch on branch mispredict or jump and flushes the affected stages. It also owns the 2-bit branch history table that supplies fetch-stage predictions and is trained from EX.

---
 rtl/cpu_ctrl_pkg.sv | 43 ++++
 rtl/bht_2bit.sv | 62 ++++++
 rtl/hazard_ctrl_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the pipeline control slice of the 5-stage CPU:
//   - nexttype_e    : branch-unit verdict coming back from EX
//   - PCSRC_*       : encodings for the PC mux select
//   - hz_state_e    : hazard FSM states
//   - BHT_RESET_VAL : power-up value of every branch history counter
//   - bht_train()   : 2-bit saturating counter update
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        PCPLUS4      = 2'd0,
        BRANCH_OK    = 2'd1,
        BRANCH_WRONG = 2'd2,
        JUMP         = 2'd3
    } nexttype_e;

    localparam logic [1:0] PCSRC_SEQ     = 2'd0;
    localparam logic [1:0] PCSRC_JUMP    = 2'd1;
    localparam logic [1:0] PCSRC_RECOVER = 2'd2;

    // Weakly not-taken: one taken outcome flips the prediction.
    localparam logic [1:0] BHT_RESET_VAL = 2'b01;

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } hz_state_e;

    // Move a 2-bit counter toward taken (3) or not-taken (0), saturating.
    function automatic logic [1:0] bht_train(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != 2'b11) begin
            res = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// ---------------------------------------------------------------------------
// bht_2bit
// Branch history table of BHT_DEPTH 2-bit saturating counters.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (all entries -> 01)
//   rd_pc           : fetch PC, combinational read port
//   rd_taken        : MSB of the addressed counter (prediction)
//   upd_valid       : train the entry addressed by upd_pc this cycle
//   upd_pc          : PC of the resolved branch
//   upd_taken       : actual outcome of that branch
// Index is pc[$clog2(BHT_DEPTH)+1:2]. A read and update of the same entry in
// one cycle returns the value held before the update (no bypass).
// ---------------------------------------------------------------------------
module bht_2bit
    import cpu_ctrl_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_taken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int IW = $clog2(BHT_DEPTH);

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] upd_idx;
    logic [1:0]    cnt_q [BHT_DEPTH];

    assign rd_idx  = rd_pc[IW+1:2];
    assign upd_idx = upd_pc[IW+1:2];

    // Only the index field of each PC is meaningful here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc[PC_W-1:IW+2], rd_pc[1:0],
                              upd_pc[PC_W-1:IW+2], upd_pc[1:0]};

    // One register per entry so every counter can be reset in one cycle.
    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_entry
            logic [1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= BHT_RESET_VAL;
                end else if (upd_valid && upd_idx == IW'(gi)) begin
                    cnt_reg <= bht_train(cnt_reg, upd_taken);
                end
            end

            assign cnt_q[gi] = cnt_reg;
        end
    endgenerate

    assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
// Pipeline hazard / control unit for the 5-stage CPU.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   ex_nexttype                      : EX verdict (PCPLUS4/BRANCH_OK/BRANCH_WRONG/JUMP)
//   idex_memread, idex_rt            : load in ID/EX and its destination
//   ifid_rs, ifid_rt, ifid_uses_rt   : sources of the instruction in IF/ID
//   if_pc, if_predict_taken          : fetch PC and its BHT prediction
//   ex_br_valid, ex_br_pc, ex_br_taken : resolved conditional branch (BHT training)
//   pc_write, pc_src                 : PC enable and PC mux select
//   ifid_stall, ifid_flush, idex_flush : pipeline register controls
//   stall_count, flush_count         : saturating performance counters
// A load-use hazard holds the front end for LOAD_LAT cycles; a redirect
// (mispredict or jump) overrides any stall and flushes IF/ID and ID/EX.
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int PC_W      = 32,
    parameter int LOAD_LAT  = 1,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ex_nexttype,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_predict_taken,
    input  logic              ex_br_valid,
    input  logic [PC_W-1:0]   ex_br_pc,
    input  logic              ex_br_taken,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    // remain never exceeds LOAD_LAT-1.
    localparam int RW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    hz_state_e   state_reg, state_next, state_eff;
    logic [RW-1:0] remain_reg, remain_next;
    nexttype_e   nt;
    logic        haz;
    logic        redirect;

    assign nt       = nexttype_e'(ex_nexttype);
    assign redirect = (nt == BRANCH_WRONG) || (nt == JUMP);
    assign haz      = idex_memread && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    // While reset is held the outputs decode as RUN, whatever the register holds.
    assign state_eff = rst ? RUN : state_reg;

    always_comb begin
        pc_write    = 1'b1;
        pc_src      = PCSRC_SEQ;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        state_next  = state_eff;
        remain_next = remain_reg;

        if (redirect) begin
            pc_write    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pc_src      = (nt == BRANCH_WRONG) ? PCSRC_RECOVER : PCSRC_JUMP;
            state_next  = RUN;
            remain_next = '0;
        end else if (state_eff == LSTALL) begin
            pc_write   = 1'b0;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            // The cycle with remain==1 is the last stall cycle.
            if (remain_reg <= RW'(1)) begin
                state_next  = RUN;
                remain_next = '0;
            end else begin
                remain_next = remain_reg - RW'(1);
            end
        end else if (haz) begin
            pc_write   = 1'b0;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            // This cycle is the first of LOAD_LAT stall cycles.
            if (LOAD_LAT > 1) begin
                state_next  = LSTALL;
                remain_next = RW'(LOAD_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= RUN;
            remain_reg <= '0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_write && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (ifid_flush && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH),
        .PC_W      (PC_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (if_pc),
        .rd_taken  (if_predict_taken),
        .upd_valid (ex_br_valid),
        .upd_pc    (ex_br_pc),
        .upd_taken (ex_br_taken)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Two instances share one stimulus stream: LOAD_LAT=1 (a_*) and LOAD_LAT=3
// (b_*). A behavioural model tracks remaining stall cycles as plain integers,
// the BHT as an int array and the counters as ints.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ex_nexttype;
    logic        idex_memread;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        ifid_uses_rt;
    logic [31:0] if_pc;
    logic        ex_br_valid;
    logic [31:0] ex_br_pc;
    logic        ex_br_taken;

    logic        a_pred, a_pw, a_st, a_ifl, a_idf;
    logic [1:0]  a_src;
    logic [31:0] a_sc, a_fc;
    logic        b_pred, b_pw, b_st, b_ifl, b_idf;
    logic [1:0]  b_src;
    logic [31:0] b_sc, b_fc;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LOAD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .ex_nexttype(ex_nexttype),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .if_pc(if_pc), .if_predict_taken(a_pred),
        .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken),
        .pc_write(a_pw), .pc_src(a_src), .ifid_stall(a_st),
        .ifid_flush(a_ifl), .idex_flush(a_idf),
        .stall_count(a_sc), .flush_count(a_fc)
    );

    hazard_ctrl_unit #(.LOAD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .ex_nexttype(ex_nexttype),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .if_pc(if_pc), .if_predict_taken(b_pred),
        .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc), .ex_br_taken(ex_br_taken),
        .pc_write(b_pw), .pc_src(b_src), .ifid_stall(b_st),
        .ifid_flush(b_ifl), .idex_flush(b_idf),
        .stall_count(b_sc), .flush_count(b_fc)
    );

    int tests = 0;
    int fails = 0;

    // Reference state
    int          left_a, left_b;     // stall cycles still owed after this one
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
    int          bht [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control outputs for one instance given how many stall cycles it still owes.
    task automatic ref_ctrl(input int left, input int lat,
                            output logic pw, output logic [1:0] src,
                            output logic st, output logic fl, output logic xf,
                            output int nleft);
        logic haz;
        int   l;
        l   = rst ? 0 : left;
        haz = idex_memread && idex_rt != 0 &&
              (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
        pw = 1; src = 0; st = 0; fl = 0; xf = 0; nleft = 0;
        if (ex_nexttype == 2 || ex_nexttype == 3) begin
            fl = 1; xf = 1;
            src = (ex_nexttype == 2) ? 2'd2 : 2'd1;
        end else if (l > 0) begin
            pw = 0; st = 1; xf = 1; nleft = l - 1;
        end else if (haz) begin
            pw = 0; st = 1; xf = 1; nleft = lat - 1;
        end
    endtask

    // One clock cycle: check combinational outputs and counters, then advance.
    task automatic step(input string tag);
        logic pw, st, fl, xf; logic [1:0] src; int na;
        logic pwb, stb, flb, xfb; logic [1:0] srcb; int nb;
        logic pred;
        #2;
        ref_ctrl(left_a, 1, pw, src, st, fl, xf, na);
        ref_ctrl(left_b, 3, pwb, srcb, stb, flb, xfb, nb);
        pred = bht[(if_pc >> 2) & 15] >= 2;
        chk({tag, ".a_pc_write"}, 32'(a_pw), 32'(pw));
        chk({tag, ".a_pc_src"}, 32'(a_src), 32'(src));
        chk({tag, ".a_ifid_stall"}, 32'(a_st), 32'(st));
        chk({tag, ".a_ifid_flush"}, 32'(a_ifl), 32'(fl));
        chk({tag, ".a_idex_flush"}, 32'(a_idf), 32'(xf));
        chk({tag, ".b_pc_write"}, 32'(b_pw), 32'(pwb));
        chk({tag, ".b_pc_src"}, 32'(b_src), 32'(srcb));
        chk({tag, ".b_ifid_stall"}, 32'(b_st), 32'(stb));
        chk({tag, ".b_ifid_flush"}, 32'(b_ifl), 32'(flb));
        chk({tag, ".b_idex_flush"}, 32'(b_idf), 32'(xfb));
        chk({tag, ".a_predict"}, 32'(a_pred), 32'(pred));
        chk({tag, ".b_predict"}, 32'(b_pred), 32'(pred));
        if (!rst) begin
            chk({tag, ".a_stall_count"}, a_sc, sc_a);
            chk({tag, ".a_flush_count"}, a_fc, fc_a);
            chk({tag, ".b_stall_count"}, b_sc, sc_b);
            chk({tag, ".b_flush_count"}, b_fc, fc_b);
        end
        $display("[TB] %s nt=%0d mr=%0d rt=%0d rs=%0d pc=%0h : a pw=%0d src=%0d b pw=%0d src=%0d pred=%0d",
                 tag, ex_nexttype, idex_memread, idex_rt, ifid_rs, if_pc, a_pw, a_src, b_pw, b_src, a_pred);
        @(posedge clk);
        if (rst) begin
            left_a = 0; left_b = 0;
            sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
            for (int i = 0; i < 16; i++) bht[i] = 1;
        end else begin
            left_a = na; left_b = nb;
            if (!pw  && sc_a != 32'hFFFF_FFFF) sc_a++;
            if (fl   && fc_a != 32'hFFFF_FFFF) fc_a++;
            if (!pwb && sc_b != 32'hFFFF_FFFF) sc_b++;
            if (flb  && fc_b != 32'hFFFF_FFFF) fc_b++;
            if (ex_br_valid) begin
                int k;
                k = (ex_br_pc >> 2) & 15;
                if (ex_br_taken) bht[k] = (bht[k] == 3) ? 3 : bht[k] + 1;
                else             bht[k] = (bht[k] == 0) ? 0 : bht[k] - 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        ex_nexttype = 0; idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
        ifid_uses_rt = 0; ex_br_valid = 0; ex_br_pc = 0; ex_br_taken = 0;
    endtask

    task automatic load_use();
        idle(); idex_memread = 1; idex_rt = 5; ifid_rs = 5;
    endtask

    initial begin
        left_a = 0; left_b = 0;
        sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
        for (int i = 0; i < 16; i++) bht[i] = 1;
        idle(); if_pc = 32'h40; rst = 1;
        @(posedge clk); #1;

        // Reset decode with idle inputs
        step("reset");
        chk("reset.predict_literal", 32'(a_pred), 32'd0);
        rst = 0; idle();
        step("idle0");

        // Single load-use hazard: 1 stall cycle for a, 3 for b
        load_use(); step("haz");
        idle(); step("haz+1"); step("haz+2"); step("haz+3");
        chk("haz.a_stall_total", a_sc, 32'd1);
        chk("haz.b_stall_total", b_sc, 32'd3);

        // Non-hazards: r0 destination, rt match without rt use
        idle(); idex_memread = 1; idex_rt = 0; ifid_rs = 0; step("r0");
        idle(); idex_memread = 1; idex_rt = 7; ifid_rt = 7; ifid_rs = 1; step("rt_unused");
        ifid_uses_rt = 1; step("rt_used");
        idle(); step("idle1"); step("idle2");

        // Mispredict in b's second stall cycle
        load_use(); step("bw_haz");
        idle(); ex_nexttype = 2; step("bw_redirect");
        idle(); step("bw_after"); step("bw_after2");
        chk("bw.b_flush_total", b_fc, 32'd1);
        chk("bw.a_flush_total", a_fc, 32'd1);

        // BHT training on 0x40
        idle(); if_pc = 32'h40; step("bht_init");
        ex_br_valid = 1; ex_br_pc = 32'h40; ex_br_taken = 1;
        step("bht_t1"); step("bht_t2");
        chk("bht.after2_literal", 32'(a_pred), 32'd1);
        ex_br_taken = 0;
        step("bht_nt1"); step("bht_nt2"); step("bht_nt3"); step("bht_nt4");
        ex_br_valid = 0; step("bht_floor");
        chk("bht.floor_literal", 32'(b_pred), 32'd0);
        ex_br_valid = 1; ex_br_taken = 1; step("bht_recover");
        ex_br_valid = 0; step("bht_check");

        // Jump with no hazard
        idle(); ex_nexttype = 3; step("jump");

        // Reset in the middle of b's stall
        idle(); load_use(); step("rst_haz");
        idle(); rst = 1; step("rst_mid");
        rst = 0; step("rst_after");
        chk("rst.b_stall_literal", b_sc, 32'd0);
        chk("rst.b_flush_literal", b_fc, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 7);
            ex_nexttype  = (r < 5) ? 2'd0 : 2'(r - 4);
            idex_memread = 1'($urandom_range(0, 1));
            idex_rt      = 5'($urandom_range(0, 3));
            ifid_rs      = 5'($urandom_range(0, 3));
            ifid_rt      = 5'($urandom_range(0, 3));
            ifid_uses_rt = 1'($urandom_range(0, 1));
            if_pc        = 32'($urandom_range(0, 63)) << 2;
            ex_br_valid  = 1'($urandom_range(0, 1));
            ex_br_pc     = 32'($urandom_range(0, 63)) << 2;
            ex_br_taken  = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 63) == 0);
            step("rand");
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
